// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy and status control for an 8-entry FIFO.
// Holds no data; it drives a one-hot write enable into an external register
// file and a select into an external first-word-fall-through read mux.
module fifo_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       rd_en,
  output logic [7:0] we,
  output logic [2:0] rd_addr,
  output logic [3:0] data_count,
  output logic       full,
  output logic       empty,
  output logic       wr_ack,
  output logic       wr_err,
  output logic       rd_ack,
  output logic       rd_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    READ   = 3'd2,
    RDWR   = 3'd3,
    WR_ERR = 3'd4,
    RD_ERR = 3'd5
  } state_t;

  logic [2:0] head_q, head_d;
  logic [2:0] tail_q, tail_d;
  logic [3:0] count_q, count_d;
  state_t     state_q, state_d;

  logic wr_ok;
  logic rd_ok;

  // Status flags come straight from the occupancy register.
  assign full       = (count_q == 4'd8);
  assign empty      = (count_q == 4'd0);
  assign data_count = count_q;
  assign rd_addr    = head_q;

  // Ack/err pulses are a pure decode of the registered state, so they never
  // depend combinationally on the request inputs.
  assign wr_ack = (state_q == WRITE) || (state_q == RDWR);
  assign rd_ack = (state_q == READ)  || (state_q == RDWR);
  assign wr_err = (state_q == WR_ERR);
  assign rd_err = (state_q == RD_ERR);

  // Accept requests against the current flags, decode write enable and next state.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    wr_ok   = wr_en & ~full;
    rd_ok   = rd_en & ~empty;
    we      = 8'h00;
    tail_d  = tail_q + {2'b00, wr_ok};
    head_d  = head_q + {2'b00, rd_ok};
    count_d = count_q + {3'b000, wr_ok} - {3'b000, rd_ok};
    state_d = IDLE;

    // Requests are ignored while reset is held, so the register file is never
    // written during a reset cycle.
    if (wr_ok && !reset) begin
      we = 8'h01 << tail_q;
    end

    if (wr_ok && rd_ok) begin
      state_d = RDWR;
    end else if (wr_ok) begin
      state_d = WRITE;
    end else if (rd_ok) begin
      state_d = READ;
    end else if (wr_en) begin
      // A push reaching here was refused because the FIFO is full; it wins
      // over a simultaneously refused pop.
      state_d = WR_ERR;
    end else if (rd_en) begin
      state_d = RD_ERR;
    end else begin
      state_d = IDLE;
    end
  end

  // Pointer, occupancy and state registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      head_q  <= 3'd0;
      tail_q  <= 3'd0;
      count_q <= 4'd0;
      state_q <= IDLE;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

endmodule
